prefix_add_nibble_sequencer: RTL and testbench

//   Multi-cycle wide adder controller. Accepts one WIDTH-bit operand pair over a valid/ready

---
 rtl/prefix_add_nibble_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_prefix_add_nibble_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_add_nibble_sequencer.sv
// prefix_add_nibble_sequencer
//   Multi-cycle wide adder controller. One WIDTH-bit operand pair is accepted over a
//   valid/ready handshake and summed one nibble per cycle (LSB first) through a single
//   4-bit prefix-adder slice, with the inter-nibble carry held in a register. The
//   registered result is returned over a second valid/ready handshake.
//
//   Optional feature macro: ADDSEQ_SUB_EN
//     Adds a `sub` input. When sub=1 at the accept edge, ~b is latched and the carry
//     register is seeded with 1, so the result is a-b (cin ignored). In that case
//     cout=1 means no borrow.

module prefix_add_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // Reject widths the nibble slicing cannot represent.
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : gen_width_check
        $error("prefix_add_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    // Current slice operands and results.
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [3:0]         nib_p;
    logic [3:0]         nib_g;
    logic [3:0]         nib_cv;
    logic               nib_co;
    logic [3:0]         nib_s;

    // Operand B and carry seed as they will be latched on the accept edge.
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    // Select the operand seeding (plain add, or two's-complement subtract when enabled).
    always_comb begin
        b_load     = b;
        carry_load = cin;
`ifdef ADDSEQ_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    // 4-bit prefix slice: per-bit propagate/generate, carries expanded in P/G form.
    always_comb begin
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
        nib_p = nib_a ^ nib_b;
        nib_g = nib_a & nib_b;

        nib_cv[0] = carry_q;
        nib_cv[1] = nib_g[0]
                  | (nib_p[0] & carry_q);
        nib_cv[2] = nib_g[1]
                  | (nib_p[1] & nib_g[0])
                  | (nib_p[1] & nib_p[0] & carry_q);
        nib_cv[3] = nib_g[2]
                  | (nib_p[2] & nib_g[1])
                  | (nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        nib_co    = nib_g[3]
                  | (nib_p[3] & nib_g[2])
                  | (nib_p[3] & nib_p[2] & nib_g[1])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);

        nib_s = nib_p ^ nib_cv;
    end

    // Next-state and datapath update: accept in idle, one nibble per run cycle, hold in done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[{idx_q, 2'b00} +: 4] = nib_s;
                carry_d = nib_co;
                if (idx_q == LAST_IDX) begin
                    // Last nibble: capture the final carry, idx stays put.
                    cout_d  = nib_co;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_prefix_add_nibble_sequencer.sv
// tb_prefix_add_nibble_sequencer
//   Directed cases with literal expectations plus randomized operations, checked every
//   cycle against a transaction-level model of the adder sequencer.

module tb_prefix_add_nibble_sequencer;

    localparam int W       = 16;
    localparam int NIBBLES = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int total;
    int bad;
    bit mon_en;

    prefix_add_nibble_sequencer #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef ADDSEQ_SUB_EN
        .sub      (sub_v),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: idle until a valid is seen, then the result is due
    // NIBBLES edges later and held until the consumer takes it.
    bit           m_idle;
    bit           m_done;
    int           m_cnt;
    logic [W-1:0] m_sum;
    logic         m_cout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (m_idle) begin
            if (in_valid) begin
                logic [W:0]   full;
                logic [W-1:0] bb;
                logic         cc;
                bb = b;
                cc = cin;
`ifdef ADDSEQ_SUB_EN
                if (sub_v) begin
                    bb = ~b;
                    cc = 1'b1;
                end
`endif
                full   = {1'b0, a} + {1'b0, bb} + (W + 1)'(cc);
                m_sum  <= full[W-1:0];
                m_cout <= full[W];
                m_cnt  <= NIBBLES;
                m_idle <= 1'b0;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("in_ready", 32'(in_ready), 32'(m_idle));
            check("busy", 32'(busy), 32'(!m_idle));
            check("out_valid", 32'(out_valid), 32'(m_done));
            if (m_done) begin
                check("model_sum", 32'(sum), 32'(m_sum));
                check("model_cout", 32'(cout), 32'(m_cout));
            end
        end
    end

    // One operation: wait for idle, present operands, measure latency, stall, hand off.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic is, input int stall, input bit lit,
                         input logic [W-1:0] esum, input logic ecout);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("idle_before_op", 32'(in_ready), 32'd1);
        a         = ia;
        b         = ib;
        cin       = ic;
        sub_v     = is;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        sub_v    = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("latency", 32'(n), 32'(NIBBLES));
        if (lit) begin
            check("lit_sum", 32'(sum), 32'(esum));
            check("lit_cout", 32'(cout), 32'(ecout));
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = W'($urandom);
            b        = W'($urandom);
            @(posedge clk);
            #2;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            if (lit) begin
                check("stall_sum", 32'(sum), 32'(esum));
                check("stall_cout", 32'(cout), 32'(ecout));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int  n;
        bit  seen1;
        total     = 0;
        bad       = 0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub_v     = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed cases with hand-computed results.
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b1, 16'h5555, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'h0000, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 6, 1'b1, 16'h0000, 1'b1);

        // Reset in the middle of an operation.
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        a        = 16'h00FF;
        b        = 16'h0001;
        cin      = 1'b0;
        sub_v    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, 1'b1, 16'h0007, 1'b0);

        // Back-to-back with in_valid and out_ready tied high.
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        a         = 16'h0001;
        b         = 16'h0001;
        cin       = 1'b0;
        sub_v     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        a     = 16'hF0F0;
        b     = 16'h0F0F;
        n     = 0;
        seen1 = 1'b0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
            if (out_valid) begin
                seen1 = 1'b1;
                check("b2b_sum1", 32'(sum), 32'h0002);
                check("b2b_cout1", 32'(cout), 32'd0);
            end
        end
        @(posedge clk);
        #2;
        n++;
        check("b2b_spacing", 32'(n), 32'd6);
        check("b2b_seen1", 32'(seen1), 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("b2b_latency2", 32'(n), 32'(NIBBLES));
        check("b2b_sum2", 32'(sum), 32'hFFFF);
        check("b2b_cout2", 32'(cout), 32'd0);
        @(posedge clk);
        #2;

`ifdef ADDSEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b1, 16'hFFFE, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b1, 16'h0002, 1'b1);
`endif

        // Randomized operations, checked by the model.
        for (int k = 0; k < 150; k++) begin
            int gap;
            logic is;
            gap = $urandom_range(0, 2);
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #2;
            end
`ifdef ADDSEQ_SUB_EN
            is = 1'($urandom);
`else
            is = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), 1'($urandom), is, $urandom_range(0, 3),
                  1'b0, '0, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
